// File: rtl/shift_pkg.sv
// Shared types for the shifter result path.
// Direction encoding and the packed {N, Z, C, S} flag bundle.
package shift_pkg;

  localparam int BUS_DEFAULT = 4;

  typedef enum logic {
    SHIFT_LEFT,
    SHIFT_RIGHT
  } shift_dir_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic s;
  } shift_flags_t;

endpackage

// File: rtl/shift_result_stage_if.sv
// Handshake bundle between the shifters, the result stage and its consumer.
// The stage itself uses the slave view.
interface shift_result_stage_if #(
  parameter int BUS = 4
);
  import shift_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic           dir;
  logic [BUS-1:0] a;
  logic [BUS-1:0] b;
  logic [BUS-1:0] y;
  logic           out_valid;
  logic           out_ready;
  logic [BUS-1:0] out_y;
  shift_flags_t   out_flags;

  modport master (
    output in_valid, dir, a, b, y, out_ready,
    input  in_ready, out_valid, out_y, out_flags
  );

  modport slave (
    input  in_valid, dir, a, b, y, out_ready,
    output in_ready, out_valid, out_y, out_flags
  );

endinterface

// File: rtl/shift_flags.sv
// Status flags for a logical shift: negative, zero, last bit out, saturated.
// Purely combinational so the ALU flag logic can reuse it.
module shift_flags
  import shift_pkg::*;
#(
  parameter int BUS = BUS_DEFAULT
) (
  input  logic [BUS-1:0] a,
  input  logic [BUS-1:0] b,
  input  logic [BUS-1:0] y,
  input  shift_dir_t     dir,
  output shift_flags_t   flags
);

  localparam logic [BUS:0] BUS_W = (BUS+1)'(BUS);

  logic         sat;
  logic         carry;
  logic [BUS:0] lsh;
  logic [BUS:0] rsh;

  // Guard bit catches a[BUS-b] (left) or a[b-1] (right); b==0 yields 0.
  assign lsh   = {1'b0, a} << b;
  assign rsh   = {a, 1'b0} >> b;
  assign sat   = ({1'b0, b} >= BUS_W);
  assign carry = !sat && ((dir == SHIFT_LEFT) ? lsh[BUS] : rsh[0]);

  assign flags.n = y[BUS-1];
  assign flags.z = (y == '0);
  assign flags.c = carry;
  assign flags.s = sat;

endmodule

// File: rtl/shift_result_stage.sv
// Registered shifter result stage: 2-entry FIFO of {y, flags}.
// in_ready depends only on the registered occupancy.
module shift_result_stage
  import shift_pkg::*;
#(
  parameter int BUS = BUS_DEFAULT
) (
  input logic                 clk,
  input logic                 rst_n,
  shift_result_stage_if.slave io
);

  typedef struct packed {
    logic [BUS-1:0] y;
    shift_flags_t   f;
  } entry_t;

  entry_t       mem [2];
  logic [1:0]   count;
  logic         wptr;
  logic         rptr;
  logic         push;
  logic         pop;
  shift_flags_t new_f;

  shift_flags #(
    .BUS(BUS)
  ) u_flags (
    .a    (io.a),
    .b    (io.b),
    .y    (io.y),
    .dir  (shift_dir_t'(io.dir)),
    .flags(new_f)
  );

  assign io.in_ready  = (count != 2'd2);
  assign io.out_valid = (count != 2'd0);

  assign push = io.in_valid && io.in_ready;
  assign pop  = io.out_valid && io.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= '{y: io.y, f: new_f};
        wptr      <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign io.out_y     = io.out_valid ? mem[rptr].y : '0;
  assign io.out_flags = io.out_valid ? mem[rptr].f : '0;

endmodule
